// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states, fault codes and
// the SYSTEM-opcode words that stop the fetch loop.
package rv_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FETCH,
    ISSUE,
    EXEC,
    HALTED,
    FAULT
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_DONE     = 2'd3;

  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;

  // ECALL and EBREAK differ only in bit 20; both carry the SYSTEM opcode.
  function automatic logic is_halt_word(input logic [31:0] w);
    return (w[6:0] == OPC_SYSTEM) &&
           ((w[31:7] == ECALL_WORD[31:7]) || (w[31:7] == EBREAK_WORD[31:7]));
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Feeds the multi-cycle RV32I core: fetches the word at the core's PC, issues it with a
// one-cycle run pulse, and waits for done before fetching the next one.
module instr_fetch_sequencer
  import rv_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      pc_in,
  input  logic             done_in,
  output logic             run,
  output logic [31:0]      command,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);

  fetch_state_e     r_state, w_next_state;
  logic [1:0]       r_fault_code, w_fault_code;
  logic [31:0]      r_command;
  logic [31:0]      r_addr;
  logic [15:0]      r_to_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_stop_pending;
  logic             w_busy;
  logic             w_accept;
  logic             w_retire;

  assign w_busy   = (r_state != IDLE) && (r_state != HALTED) && (r_state != FAULT);
  // An ack coinciding with a spurious done is not accepted: the block faults instead.
  assign w_accept = (r_state == FETCH) && imem_ack && !done_in;
  assign w_retire = (r_state == EXEC) && done_in;

  always_comb begin
    w_next_state = r_state;
    w_fault_code = r_fault_code;
    unique case (r_state)
      IDLE: begin
        if (done_in) begin
          w_next_state = FAULT;
          w_fault_code = FC_DONE;
        end else if (start) begin
          w_next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (done_in) begin
          w_next_state = FAULT;
          w_fault_code = FC_DONE;
        end else if (pc_in[1:0] != 2'b00) begin
          w_next_state = FAULT;
          w_fault_code = FC_MISALIGN;
        end else begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        if (done_in) begin
          w_next_state = FAULT;
          w_fault_code = FC_DONE;
        end else if (imem_ack) begin
          w_next_state = is_halt_word(imem_rdata) ? HALTED : ISSUE;
        end else if (r_to_cnt == ToLast) begin
          w_next_state = FAULT;
          w_fault_code = FC_TIMEOUT;
        end
      end
      ISSUE: begin
        if (done_in) begin
          w_next_state = FAULT;
          w_fault_code = FC_DONE;
        end else begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (done_in) begin
          w_next_state = (r_stop_pending || stop) ? IDLE : SETTLE;
        end
      end
      HALTED, FAULT: w_next_state = r_state;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_fault_code   <= FC_NONE;
      r_command      <= '0;
      r_addr         <= '0;
      r_to_cnt       <= '0;
      r_retired      <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_fault_code <= w_fault_code;
      if (w_accept) r_command <= imem_rdata;
      if (r_state == SETTLE) r_addr <= pc_in;
      r_to_cnt <= ((r_state == FETCH) && (w_next_state == FETCH)) ? r_to_cnt + 16'd1 : '0;
      if (w_retire) r_retired <= r_retired + 1'b1;
      if (w_retire && (w_next_state == IDLE)) begin
        r_stop_pending <= 1'b0;
      end else if (stop && w_busy) begin
        r_stop_pending <= 1'b1;
      end
    end
  end

  // Decoded from the state register so reset clears them without waiting for an edge.
  assign run        = (r_state == ISSUE);
  assign imem_req   = (r_state == FETCH);
  assign busy       = w_busy;
  assign halted     = (r_state == HALTED);
  assign fault      = (r_state == FAULT);
  assign fault_code = r_fault_code;
  assign command    = r_command;
  assign imem_addr  = r_addr;
  assign retired    = r_retired;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: hand-driven memory and core strobes with
// hand-computed expectations.
module tb_instr_fetch_sequencer;

  localparam logic [31:0] AddiWord   = 32'h0050_0093;
  localparam logic [31:0] AddWord    = 32'h0020_8133;
  localparam logic [31:0] EbreakWord = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] pc_in = '0;
  logic        done_in = 1'b0;
  logic        run;
  logic [31:0] command;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_sequencer #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pc_in     (pc_in),
    .done_in   (done_in),
    .run       (run),
    .command   (command),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".run"}, 32'(run), 0);
    check({tag, ".command"}, command, 0);
    check({tag, ".req"}, 32'(imem_req), 0);
    check({tag, ".addr"}, imem_addr, 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".halted"}, 32'(halted), 0);
    check({tag, ".fault"}, 32'(fault), 0);
    check({tag, ".code"}, 32'(fault_code), 0);
    check({tag, ".retired"}, retired, 0);
  endtask

  task automatic do_reset();
    cyc();
    start = 0; stop = 0; done_in = 0; imem_ack = 0; pc_in = 0;
    reset = 1;
    #2;
    reset = 0;
    cyc();
  endtask

  // Pulse start at pc, leaving the DUT in its first FETCH cycle.
  task automatic start_fetch(input logic [31:0] pc);
    pc_in = pc;
    start = 1;
    cyc();
    start = 0;
    cyc();
  endtask

  task automatic ack_now(input logic [31:0] word);
    imem_ack = 1;
    imem_rdata = word;
    cyc();
    imem_ack = 0;
  endtask

  initial begin
    // 1: addi then EBREAK, zero-wait memory.
    cyc();
    check_all_zero("t1.reset");
    do_reset();
    pc_in = 32'h0;
    start = 1;
    cyc();
    start = 0;
    check("t1.settle_busy", 32'(busy), 1);
    check("t1.settle_noreq", 32'(imem_req), 0);
    cyc();
    check("t1.fetch_req", 32'(imem_req), 1);
    check("t1.fetch_addr", imem_addr, 32'h0);
    ack_now(AddiWord);
    check("t1.run_t3", 32'(run), 1);
    check("t1.cmd", command, AddiWord);
    cyc();
    check("t1.run_one_cycle", 32'(run), 0);
    cyc();
    done_in = 1;
    cyc();
    done_in = 0;
    pc_in = 32'h4;
    check("t1.retired", retired, 1);
    cyc();
    check("t1.addr4", imem_addr, 32'h4);
    ack_now(EbreakWord);
    check("t1.halted", 32'(halted), 1);
    check("t1.halt_run", 32'(run), 0);
    check("t1.halt_busy", 32'(busy), 0);
    check("t1.halt_cmd", command, EbreakWord);
    start = 1;
    cyc();
    cyc();
    start = 0;
    check("t1.halt_sticky", 32'(halted), 1);
    check("t1.halt_norun", 32'(run), 0);
    check("t1.halt_retired", retired, 1);

    // 2: ack on the 4th request cycle, which is also the timeout boundary; ack wins.
    do_reset();
    start_fetch(32'h10);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2.req%0d", i), 32'(imem_req), 1);
      check($sformatf("t2.addr%0d", i), imem_addr, 32'h10);
      check($sformatf("t2.cmd_hold%0d", i), command, 0);
      if (i == 4) begin
        ack_now(AddWord);
      end else begin
        cyc();
      end
    end
    check("t2.run", 32'(run), 1);
    check("t2.cmd", command, AddWord);
    check("t2.nofault", 32'(fault), 0);

    // 3: no ack -> timeout after 4 request cycles.
    do_reset();
    start_fetch(32'h20);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3.req%0d", i), 32'(imem_req), 1);
      cyc();
    end
    check("t3.req_low", 32'(imem_req), 0);
    check("t3.fault", 32'(fault), 1);
    check("t3.code", 32'(fault_code), 2);
    start = 1;
    cyc();
    cyc();
    start = 0;
    check("t3.start_ignored_req", 32'(imem_req), 0);
    check("t3.start_ignored_busy", 32'(busy), 0);
    check("t3.code_held", 32'(fault_code), 2);

    // 4: misaligned PC after a retired instruction.
    do_reset();
    start_fetch(32'h0);
    ack_now(AddiWord);
    cyc();
    done_in = 1;
    cyc();
    done_in = 0;
    pc_in = 32'h6;
    cyc();
    check("t4.fault", 32'(fault), 1);
    check("t4.code", 32'(fault_code), 1);
    check("t4.noreq", 32'(imem_req), 0);
    cyc();
    check("t4.noreq_later", 32'(imem_req), 0);

    // 5: stop in EXEC, done two cycles later, then resume.
    do_reset();
    start_fetch(32'h0);
    ack_now(AddiWord);
    cyc();
    stop = 1;
    cyc();
    stop = 0;
    cyc();
    done_in = 1;
    cyc();
    done_in = 0;
    pc_in = 32'h40;
    check("t5.retired", retired, 1);
    check("t5.idle_busy", 32'(busy), 0);
    check("t5.idle_req", 32'(imem_req), 0);
    cyc();
    check("t5.still_idle", 32'(busy), 0);
    start = 1;
    cyc();
    start = 0;
    cyc();
    check("t5.resume_req", 32'(imem_req), 1);
    check("t5.resume_addr", imem_addr, 32'h40);
    ack_now(AddWord);
    check("t5.resume_run", 32'(run), 1);

    // 6: spurious done in FETCH, then asynchronous reset mid-cycle.
    do_reset();
    start_fetch(32'h0);
    ack_now(AddiWord);
    cyc();
    done_in = 1;
    cyc();
    done_in = 0;
    pc_in = 32'h8;
    cyc();
    done_in = 1;
    cyc();
    done_in = 0;
    check("t6.code", 32'(fault_code), 3);
    check("t6.fault", 32'(fault), 1);
    #2;
    reset = 1;
    #1;
    check_all_zero("t6.async");
    reset = 0;
    cyc();
    start_fetch(32'hC);
    check("t6.req_before", 32'(imem_req), 1);
    #2;
    reset = 1;
    #1;
    check("t6.req_drop", 32'(imem_req), 0);
    check("t6.addr_drop", imem_addr, 0);
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
